// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR controller: one shared 32x11 radix-4 Booth multiplier
// walks all taps of a direct-form delay line, one product per cycle.
module fir_mac_sched #(
    parameter int unsigned NTAPS = 8,
    parameter int unsigned AW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [10:0]   cfg_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StMac   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StOut   = 2'd3;

    localparam logic [AW-1:0] LastTap = AW'(NTAPS - 1);

    logic [1:0]    state_q, state_d;
    logic [31:0]   d_q [NTAPS];
    logic [10:0]   c_q [NTAPS];
    logic [31:0]   acc_q;
    logic [31:0]   p_q;
    logic          pv_q;
    logic [AW-1:0] k_q;

    logic          accept;
    logic          cfg_ok;

    assign accept = (state_q == StIdle) && in_valid;
    assign cfg_ok = cfg_we && (state_q == StIdle) && (32'(cfg_addr) < NTAPS);

    // Radix-4 Booth: six signed digits from the 11-bit coefficient.
    logic [31:0] mul_x;
    logic [10:0] mul_y;
    logic [12:0] booth_y;
    logic [42:0] mul_xe;
    logic [42:0] pp;
    logic [42:0] prod;
    logic [31:0] mul_p;
    logic        mul_unused;

    assign mul_x = d_q[k_q];
    assign mul_y = c_q[k_q];

    always_comb begin
        booth_y = {mul_y[10], mul_y, 1'b0};
        mul_xe  = {{11{mul_x[31]}}, mul_x};
        prod    = '0;
        pp      = '0;
        for (int i = 0; i < 6; i++) begin
            case (booth_y[2*i +: 3])
                3'b001, 3'b010: pp = mul_xe;
                3'b011:         pp = mul_xe << 1;
                3'b100:         pp = -(mul_xe << 1);
                3'b101, 3'b110: pp = -mul_xe;
                default:        pp = '0;
            endcase
            prod = prod + (pp << (2 * i));
        end
    end

    // Q1.10 scaling: arithmetic shift by 10 is a floor divide.
    assign mul_p      = prod[41:10];
    assign mul_unused = ^{prod[42], prod[9:0]};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StMac;
            StMac:   if (k_q == LastTap) state_d = StDrain;
            StDrain: state_d = StOut;
            StOut:   if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            p_q     <= '0;
            pv_q    <= 1'b0;
            k_q     <= '0;
            for (int unsigned i = 0; i < NTAPS; i++) begin
                d_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (cfg_ok) begin
                c_q[cfg_addr] <= cfg_data;
            end
            if (accept) begin
                d_q[0] <= in_data;
                for (int unsigned i = 1; i < NTAPS; i++) begin
                    d_q[i] <= d_q[i-1];
                end
                acc_q <= '0;
                k_q   <= '0;
                pv_q  <= 1'b0;
            end
            if (state_q == StMac) begin
                p_q  <= mul_p;
                pv_q <= 1'b1;
                k_q  <= k_q + 1'b1;
                if (pv_q) begin
                    acc_q <= acc_q + p_q;
                end
            end
            if (state_q == StDrain) begin
                acc_q <= acc_q + p_q;
                pv_q  <= 1'b0;
            end
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign out_data  = acc_q;

endmodule
